// File: rtl/sprite_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sprite_capture : copies a WIDTH x HEIGHT region of the 1bpp pixel stream into
// a row-major buffer with a registered read port. SPRITE_CAPTURE_ABORT_EN adds
// the abort input.  Rev 1.0
// ---------------------------------------------------------------------------
module sprite_capture #(
  parameter int WIDTH   = 8,
  parameter int HEIGHT  = 8,
  parameter int SCALE_X = 1,
  parameter int SCALE_Y = 1,
  parameter int CORDW   = 10,
  parameter int DEPTH   = WIDTH*HEIGHT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CORDW-1:0]         capx,
  input  logic [CORDW-1:0]         capy,
  input  logic [CORDW-1:0]         sx,
  input  logic [CORDW-1:0]         sy,
  input  logic                     pix_in,
`ifdef SPRITE_CAPTURE_ABORT_EN
  input  logic                     abort,
`endif
  output logic                     busy,
  output logic                     done,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic                     rd_data
);
  localparam int AW  = $clog2(DEPTH);
  localparam int OXW = $clog2(WIDTH+1);
  localparam int OYW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    AWAIT_POS = 2'd1,
    CAPTURE   = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CORDW-1:0] capx_r, row_y;
  logic [AW-1:0]    pos;
  logic [OXW-1:0]   ox, ox_cur, ox_after;
  logic [OYW-1:0]   oy;
  logic [CXW-1:0]   cnt_x, cnt_cur;
  logic             mem [DEPTH];
  logic             at_origin, in_line, wr_en, line_end, last_row;
  logic             abort_hit, done_next;

`ifdef SPRITE_CAPTURE_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign at_origin = (sx == capx_r) && (sy == row_y);
  assign last_row  = (oy == OYW'(HEIGHT-1));
  assign busy      = (state != IDLE);

  // The match cycle behaves like a capture cycle with ox and cnt_x at zero.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    in_line    = 1'b0;
    cnt_cur    = '0;
    ox_cur     = '0;
    case (state)
      IDLE:      if (start) state_next = AWAIT_POS;
      AWAIT_POS: if (at_origin) begin
                   in_line    = 1'b1;
                   state_next = CAPTURE;
                 end
      CAPTURE:   begin
                   in_line = 1'b1;
                   cnt_cur = cnt_x;
                   ox_cur  = ox;
                 end
      default:   state_next = IDLE;
    endcase
    wr_en    = in_line && (cnt_cur == '0);
    ox_after = ox_cur + OXW'(wr_en);
    line_end = in_line && (ox_after == OXW'(WIDTH)) && (cnt_cur == CXW'(SCALE_X-1));
    if (line_end) begin
      state_next = last_row ? IDLE : AWAIT_POS;
      done_next  = last_row;
    end
    if (abort_hit) begin
      state_next = IDLE;
      done_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      done   <= 1'b0;
      capx_r <= '0;
      row_y  <= '0;
      pos    <= '0;
      ox     <= '0;
      oy     <= '0;
      cnt_x  <= '0;
    end else begin
      state <= state_next;
      done  <= done_next;
      if (state == IDLE) begin
        if (start) begin
          capx_r <= capx;
          row_y  <= capy;
          pos    <= '0;
          ox     <= '0;
          oy     <= '0;
          cnt_x  <= '0;
        end
      end else if (in_line) begin
        if (wr_en) pos <= pos + AW'(1);
        ox    <= ox_after;
        cnt_x <= (cnt_cur == CXW'(SCALE_X-1)) ? '0 : cnt_cur + CXW'(1);
        if (line_end && !last_row && !abort_hit) begin
          oy    <= oy + OYW'(1);
          row_y <= row_y + CORDW'(SCALE_Y);
        end
      end
    end
  end

  // Buffer is deliberately not reset so partial captures survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) mem[pos] <= pix_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= 1'b0;
    else        rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_capture.sv
`default_nettype none
// tb_sprite_capture : raster-driven bench for sprite_capture (1x scale and 2x scale instances).
module tb_sprite_capture;
  localparam int CW      = 10;
  localparam int H_TOTAL = 128;
  localparam int V_TOTAL = 64;
  localparam int BOUND   = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [CW-1:0] sx, sy;
  logic          start_a, start_b;
  logic [CW-1:0] capx_a, capy_a, capx_b, capy_b;
  logic          pix_a, pix_b;
  logic          busy_a, done_a, rd_data_a;
  logic          busy_b, done_b, rd_data_b;
  logic [5:0]    rd_addr_a;
  logic [3:0]    rd_addr_b;
`ifdef SPRITE_CAPTURE_ABORT_EN
  logic          abort_a;
`endif

  function automatic logic pat_a(input int x, input int y);
    int v;
    v = x ^ y;
    return v[0];
  endfunction

  function automatic logic pat_b(input int x, input int y);
    int v;
    v = x*37 + y*101;
    v = v ^ (v >> 3) ^ (v >> 5);
    return v[0];
  endfunction

  assign pix_a = pat_a(int'(sx), int'(sy));
  assign pix_b = pat_b(int'(sx), int'(sy));

  sprite_capture dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .capx(capx_a), .capy(capy_a),
    .sx(sx), .sy(sy), .pix_in(pix_a),
`ifdef SPRITE_CAPTURE_ABORT_EN
    .abort(abort_a),
`endif
    .busy(busy_a), .done(done_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a)
  );

  sprite_capture #(.WIDTH(4), .HEIGHT(4), .SCALE_X(2), .SCALE_Y(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .capx(capx_b), .capy(capy_b),
    .sx(sx), .sy(sy), .pix_in(pix_b),
`ifdef SPRITE_CAPTURE_ABORT_EN
    .abort(1'b0),
`endif
    .busy(busy_b), .done(done_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b)
  );

  typedef struct {
    int   due;
    bit   which;
    logic exp;
    int   addr;
  } rd_t;

  rd_t  rdq[$];
  logic mdl [64];
  int   tick_no, n_checks, n_err;
  int   done_cnt_a, done_cnt_b, done_x_a, done_y_a, done_x_b, done_y_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", tag, got, exp, tick_no);
    end
  endtask

  task automatic issue_read(input bit which, input int addr, input logic exp);
    rd_t e;
    if (which) rd_addr_b = 4'(addr);
    else       rd_addr_a = 6'(addr);
    e.due = tick_no + 1; e.which = which; e.exp = exp; e.addr = addr;
    rdq.push_back(e);
  endtask

  // One clock: sample outputs, retire due reads, then advance the raster.
  task automatic tick();
    rd_t e;
    @(posedge clk);
    #1;
    tick_no++;
    while (rdq.size() > 0 && rdq[0].due <= tick_no) begin
      e = rdq.pop_front();
      if (e.which) check($sformatf("rd_b[%0d]", e.addr), rd_data_b, e.exp);
      else         check($sformatf("rd_a[%0d]", e.addr), rd_data_a, e.exp);
    end
    if (done_a) begin
      done_cnt_a++; done_x_a = int'(sx); done_y_a = int'(sy);
      check("done_a_busy_low", busy_a, 0);
    end
    if (done_b) begin
      done_cnt_b++; done_x_b = int'(sx); done_y_b = int'(sy);
      check("done_b_busy_low", busy_b, 0);
    end
    if (int'(sx) == H_TOTAL-1) begin
      sx = '0;
      sy = (int'(sy) == V_TOTAL-1) ? '0 : sy + 1'b1;
    end else begin
      sx = sx + 1'b1;
    end
  endtask

  task automatic wait_pos(input int x, input int y);
    int t = 0;
    while (!(int'(sx) == x && int'(sy) == y) && t < BOUND) begin
      tick();
      t++;
    end
    if (t >= BOUND) check("timeout_pos", 0, 1);
  endtask

  task automatic wait_done_a();
    int t = 0;
    int base = done_cnt_a;
    while (done_cnt_a == base && t < BOUND) begin
      tick();
      t++;
    end
    if (done_cnt_a == base) check("timeout_done_a", 0, 1);
  endtask

  task automatic readback_a();
    for (int i = 0; i < 64; i++) begin
      issue_read(0, i, mdl[i]);
      tick();
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start_a = 0; start_b = 0;
    capx_a = '0; capy_a = '0; capx_b = '0; capy_b = '0;
    rd_addr_a = '0; rd_addr_b = '0; sx = '0; sy = '0;
`ifdef SPRITE_CAPTURE_ABORT_EN
    abort_a = 1'b0;
`endif
    repeat (3) tick();
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_rd_a", rd_data_a, 0);
    check("rst_busy_b", busy_b, 0);
    rst_n = 1'b1;
    tick();

    // Full capture on both instances; A gets stray starts while busy.
    start_a = 1; capx_a = 100; capy_a = 50;
    start_b = 1; capx_b = 10;  capy_b = 20;
    tick();
    start_a = 0; start_b = 0;
    check("busy_a_rise", busy_a, 1);
    check("busy_b_rise", busy_b, 1);
    begin
      int t = 0;
      while (done_cnt_a == 0 && t < BOUND) begin
        if ((t % 97) == 50 && busy_a) begin
          start_a = 1; capx_a = 5; capy_a = 3;
        end else begin
          start_a = 0;
        end
        tick();
        t++;
      end
      start_a = 0;
      if (done_cnt_a == 0) check("timeout_first_done", 0, 1);
    end
    check("done_a_x", done_x_a, 107);
    check("done_a_y", done_y_a, 57);
    check("done_b_x", done_x_b, 17);
    check("done_b_y", done_y_b, 26);
    repeat (200) tick();
    check("done_a_count", done_cnt_a, 1);
    check("done_b_count", done_cnt_b, 1);
    check("busy_a_idle", busy_a, 0);

    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        mdl[r*8+c] = pat_a(100+c, 50+r);
        issue_read(0, r*8+c, mdl[r*8+c]);
        if (r < 4 && c < 4) issue_read(1, r*4+c, pat_b(10+2*c, 20+2*r));
        tick();
      end
    end
    tick();

    // Reset after three rows of an offset (inverted) capture.
    start_a = 1; capx_a = 101; capy_a = 50;
    tick();
    start_a = 0;
    wait_pos(0, 53);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy_a, 0);
    check("midrst_done", done_a, 0);
    check("midrst_rd", rd_data_a, 0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("midrst_no_done", done_cnt_a, 1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 8; c++)
        mdl[r*8+c] = pat_a(101+c, 50+r);
    readback_a();

    // Recapture, reading address 10 in the very cycle it is written.
    start_a = 1; capx_a = 100; capy_a = 50;
    tick();
    start_a = 0;
    wait_pos(102, 51);
    issue_read(0, 10, mdl[10]);
    tick();
    issue_read(0, 10, pat_a(102, 51));
    tick();
    wait_done_a();
    check("redone_x", done_x_a, 107);
    check("redone_y", done_y_a, 57);
    for (int i = 0; i < 64; i++) mdl[i] = pat_a(100 + i % 8, 50 + i / 8);
    readback_a();

`ifdef SPRITE_CAPTURE_ABORT_EN
    begin
      int base = done_cnt_a;
      abort_a = 1; start_a = 1; capx_a = 100; capy_a = 50;
      tick();
      abort_a = 0; start_a = 0;
      check("abort_idle_start_busy", busy_a, 1);
      wait_pos(107, 54);
      abort_a = 1;
      tick();
      abort_a = 0;
      check("abort_busy_low", busy_a, 0);
      repeat (300) tick();
      check("abort_stays_idle", busy_a, 0);
      check("abort_no_done", done_cnt_a, base);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_capture.md
Name: sprite_capture

Overview:
Captures a rectangular region of the live 1-bit pixel stream into a WIDTH x HEIGHT 1bpp sprite buffer. It is the writer counterpart to the sprite draw engines, which read a graphic and emit pixels. Optional integer downscaling keeps one pixel from each SCALE_X x SCALE_Y block. It sits beside the display timing generator and uses the same sx/sy screen coordinates. The captured buffer is read back through a synchronous read port, for example by a loader that feeds a sprite memory.

Parameters:
WIDTH, 8, captured graphic width in pixels (buffer columns)
HEIGHT, 8, captured graphic height in pixels (buffer rows)
SCALE_X, 1, horizontal downscale factor; screen columns consumed per stored pixel
SCALE_Y, 1, vertical downscale factor; screen lines advanced per stored row
CORDW, 10, screen coordinate width in bits
DEPTH, WIDTH*HEIGHT, buffer depth in bits

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin capture; sampled only in IDLE
capx  in  CORDW  left screen column of the region; registered on accepted start
capy  in  CORDW  top screen line of the region; registered on accepted start
sx  in  CORDW  current horizontal screen position
sy  in  CORDW  current vertical screen position
pix_in  in  1  pixel colour at (sx,sy), valid in the same cycle
busy  out  1  high from the cycle after an accepted start until capture ends
done  out  1  one-cycle pulse when the final buffer bit has been written
rd_addr  in  $clog2(DEPTH)  buffer read address
rd_data  out  1  mem[rd_addr], registered, 1-cycle latency

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, rd_data=0; all counters cleared. Buffer contents are not cleared.
- Reset asserted mid-capture aborts immediately. Bits already written are kept; done does not pulse.
- Internal registers:
  - capx_r, row_y (CORDW bits)
  - pos ($clog2(DEPTH) bits)
  - ox, oy (column and row counters)
  - cnt_x ($clog2(SCALE_X) bits, unused when SCALE_X=1)
- States:
  - IDLE: start=1 registers capx_r=capx, row_y=capy, pos=0, oy=0, then goes to AWAIT_POS. start while not IDLE is ignored.
  - AWAIT_POS: waits for sx==capx_r && sy==row_y. The match cycle is capture cycle 0 of the line: the block writes mem[pos]<=pix_in, sets ox=0, and goes to CAPTURE. On this match-cycle write pos increments, ox becomes 1 and cnt_x becomes 1; when SCALE_X=1, cnt_x stays 0.
  - CAPTURE: consumes one screen pixel per cycle and ignores sx; the line is taken as consecutive cycles.
    - Write mem[pos]<=pix_in only when cnt_x==0, then pos+=1 and ox+=1.
    - cnt_x counts 0..SCALE_X-1 and wraps.
    - After WIDTH*SCALE_X cycles in total (including the match cycle), the line ends.
- Line end:
  - If oy==HEIGHT-1: go to IDLE, done=1 for one cycle, busy=0 in that same cycle.
  - Otherwise: oy+=1, row_y+=SCALE_Y (modulo 2^CORDW), return to AWAIT_POS.
- Lines between stored rows (SCALE_Y>1) are skipped, never written.
- busy=1 in AWAIT_POS and CAPTURE only.
- Region exceeding the right screen edge: capture continues through the blanking cycles, which is the caller's responsibility. The block does not wrap or clip.
- If row_y never occurs, for example because it is beyond the vertical resolution, the block stays in AWAIT_POS until reset or abort.
- Read port: available in every state. A read and a write to the same address in the same cycle returns the old data.
- Buffer layout: row-major, mem[oy*WIDTH+ox], matching the layout the sprite draw engines expect.

Optional Feature:
Macro SPRITE_CAPTURE_ABORT_EN.
- Defined: adds port abort (in, 1). abort=1 in AWAIT_POS or CAPTURE returns the block to IDLE on the next edge: busy=0, no done pulse, partial data kept. abort has priority over the line-end transition. abort in IDLE is ignored, and start in the same cycle is still accepted.
- Undefined: no abort port. Capture ends only by completion or reset.

Test Plan:
- WIDTH=8, HEIGHT=8, SCALE 1. start with capx=100, capy=50. Stream pix_in=(sx^sy)&1. -> busy rises the next cycle; done pulses once after line sy=57. rd_addr r*8+c returns (100+c ^ 50+r)&1.
- SCALE_X=2, SCALE_Y=2, WIDTH=HEIGHT=4, capx=10, capy=20. -> columns 10, 12, 14, 16 are stored from lines 20, 22, 24, 26; the odd columns and lines never appear in the buffer.
- start pulsed repeatedly during capture with a different capx. -> ignored; capture region and done timing unchanged.
- rst_n dropped for one cycle after 3 rows. -> busy=0, done=0 immediately. Rows 0-2 readable and unchanged. A new start then recaptures correctly.
- Read while capturing: rd_addr equal to the address being written in the same cycle. -> rd_data shows the old value one cycle later and the new value on the next read.
- SPRITE_CAPTURE_ABORT_EN defined: abort in the cycle of the row 4 line end. -> IDLE, busy=0, no done; oy not advanced.
